// File: rtl/acl_reg_sequencer.sv
// acl_reg_sequencer
// Register sequencer sitting between board control logic and the SPI register
// master. After a startup delay it writes an init table of (addr, data) pairs,
// then repeatedly reads NUM_RD consecutive registers and publishes each complete
// frame atomically on sample_data with a one-cycle sample_valid strobe.
//
// Ports:
//   sys_clk, sys_rst        clock, synchronous active-high reset
//   enable                  polling permitted (checked only between frames)
//   reg_aw*/reg_w*/reg_b*   byte register write channels (address, data, response)
//   reg_ar*/reg_r*          byte register read channels (address, data)
//   sample_data             last complete frame, byte i = register RD_BASE+i
//   sample_valid            one-cycle pulse when sample_data is updated
//   init_done               all init writes have completed
//   resp_err                sticky, set by any nonzero bresp/rresp
//
// Optional build macro: ACL_SEQ_TIMEOUT_EN enables a watchdog that restarts the
// init sequence when a transaction stalls for TIMEOUT cycles.
module acl_reg_sequencer #(
  parameter int                     NUM_INIT   = 2,
  parameter logic [NUM_INIT*14-1:0] INIT_TABLE = {6'h27, 8'h00, 6'h2D, 8'h02},
  parameter logic [5:0]             RD_BASE    = 6'h08,
  parameter int                     NUM_RD     = 3,
  parameter int                     START_WAIT = 65535,
  parameter int                     POLL_WAIT  = 1000,
  parameter int                     TIMEOUT    = 4095
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  enable,
  output logic                  reg_awvalid,
  input  logic                  reg_awready,
  output logic [5:0]            reg_awaddr,
  output logic                  reg_wvalid,
  input  logic                  reg_wready,
  output logic [7:0]            reg_wdata,
  input  logic                  reg_bvalid,
  output logic                  reg_bready,
  input  logic [1:0]            reg_bresp,
  output logic                  reg_arvalid,
  input  logic                  reg_arready,
  output logic [5:0]            reg_araddr,
  input  logic                  reg_rvalid,
  output logic                  reg_rready,
  input  logic [7:0]            reg_rdata,
  input  logic [1:0]            reg_rresp,
  output logic [NUM_RD*8-1:0]   sample_data,
  output logic                  sample_valid,
  output logic                  init_done,
  output logic                  resp_err
);

  typedef enum logic [2:0] {
    WAIT_START, INIT_WR, INIT_B, POLL_AR, POLL_R, FRAME_OUT, POLL_IDLE
  } state_t;

  localparam logic [31:0] LP_START_WAIT = 32'(START_WAIT);
  localparam logic [31:0] LP_POLL_WAIT  = 32'(POLL_WAIT);
  localparam logic [3:0]  LP_LAST_INIT  = 4'(NUM_INIT - 1);
  localparam logic [3:0]  LP_LAST_RD    = 4'(NUM_RD - 1);

  state_t                r_state, w_state_next;
  logic [31:0]           r_cnt, w_cnt_next;
  logic [3:0]            r_idx, w_idx_next;
  logic [3:0]            r_rd_idx, w_rd_idx_next;
  logic                  r_aw_done, w_aw_done_next;
  logic                  r_w_done, w_w_done_next;
  logic                  r_ar_hold, w_ar_hold_next;
  logic [NUM_RD*8-1:0]   r_shadow, w_shadow_next;
  logic [NUM_RD*8-1:0]   r_sample_data, w_sample_data_next;
  logic                  r_sample_valid, w_sample_valid_next;
  logic                  r_init_done, w_init_done_next;
  logic                  r_resp_err, w_resp_err_next;

  // Init table unpacked into a fixed 16-entry array so a 4-bit index never
  // selects outside the array; unused slots read as zero.
  logic [13:0] w_init_entry [16];
  logic [13:0] w_cur_entry;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_init
      if (gi < NUM_INIT) begin : g_used
        assign w_init_entry[gi] = INIT_TABLE[(NUM_INIT-1-gi)*14 +: 14];
      end else begin : g_unused
        assign w_init_entry[gi] = '0;
      end
    end
  endgenerate

  assign w_cur_entry = w_init_entry[r_idx];

  logic w_in_wr;
  assign w_in_wr     = (r_state == INIT_WR);
  assign reg_awvalid = w_in_wr && !r_aw_done;
  assign reg_wvalid  = w_in_wr && !r_w_done;
  assign reg_awaddr  = w_in_wr ? w_cur_entry[13:8] : 6'h00;
  assign reg_wdata   = w_in_wr ? w_cur_entry[7:0]  : 8'h00;
  assign reg_bready  = (r_state == INIT_B);
  // enable only gates the start of a frame; once arvalid is up it is held
  // (r_ar_hold) until the slave accepts, even if enable drops meanwhile.
  assign reg_arvalid = (r_state == POLL_AR) && (enable || (r_rd_idx != 4'd0) || r_ar_hold);
  assign reg_araddr  = (r_state == POLL_AR) ? (RD_BASE + {2'b00, r_rd_idx}) : 6'h00;
  assign reg_rready  = (r_state == POLL_R);

  assign sample_data  = r_sample_data;
  assign sample_valid = r_sample_valid;
  assign init_done    = r_init_done;
  assign resp_err     = r_resp_err;

`ifdef ACL_SEQ_TIMEOUT_EN
  localparam logic [31:0] LP_TIMEOUT = 32'(TIMEOUT);
  logic [31:0] r_wdog, w_wdog_next;
  logic        w_wdog_run;
  // Waiting in POLL_AR for enable is not a slave stall, so the watchdog only
  // runs there while a read address is actually being offered.
  assign w_wdog_run = (r_state == INIT_WR) || (r_state == INIT_B) || (r_state == POLL_R) ||
                      ((r_state == POLL_AR) && reg_arvalid);
`endif

  always_comb begin
    w_state_next        = r_state;
    w_cnt_next          = r_cnt;
    w_idx_next          = r_idx;
    w_rd_idx_next       = r_rd_idx;
    w_aw_done_next      = r_aw_done;
    w_w_done_next       = r_w_done;
    w_ar_hold_next      = reg_arvalid && !reg_arready;
    w_shadow_next       = r_shadow;
    w_sample_data_next  = r_sample_data;
    w_sample_valid_next = 1'b0;
    w_init_done_next    = r_init_done;
    w_resp_err_next     = r_resp_err;

    case (r_state)
      WAIT_START: begin
        if (r_cnt + 32'd1 >= LP_START_WAIT) begin
          w_state_next = INIT_WR;
          w_cnt_next   = '0;
          w_idx_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end
      INIT_WR: begin
        w_aw_done_next = r_aw_done || (reg_awvalid && reg_awready);
        w_w_done_next  = r_w_done  || (reg_wvalid  && reg_wready);
        if (w_aw_done_next && w_w_done_next) begin
          w_state_next   = INIT_B;
          w_aw_done_next = 1'b0;
          w_w_done_next  = 1'b0;
        end
      end
      INIT_B: begin
        if (reg_bvalid) begin
          if (reg_bresp != 2'b00) w_resp_err_next = 1'b1;
          if (r_idx == LP_LAST_INIT) begin
            w_init_done_next = 1'b1;
            w_state_next     = POLL_AR;
          end else begin
            w_idx_next   = r_idx + 4'd1;
            w_state_next = INIT_WR;
          end
        end
      end
      POLL_AR: begin
        if (reg_arvalid && reg_arready) w_state_next = POLL_R;
      end
      POLL_R: begin
        if (reg_rvalid) begin
          for (int i = 0; i < NUM_RD; i++) begin
            if (r_rd_idx == 4'(i)) w_shadow_next[i*8 +: 8] = reg_rdata;
          end
          if (reg_rresp != 2'b00) w_resp_err_next = 1'b1;
          if (r_rd_idx == LP_LAST_RD) begin
            // Publish the completed frame (including this last byte) so that
            // sample_data and sample_valid change together in FRAME_OUT.
            w_sample_data_next  = w_shadow_next;
            w_sample_valid_next = 1'b1;
            w_state_next        = FRAME_OUT;
          end else begin
            w_rd_idx_next = r_rd_idx + 4'd1;
            w_state_next  = POLL_AR;
          end
        end
      end
      FRAME_OUT: begin
        w_rd_idx_next = '0;
        w_cnt_next    = '0;
        w_state_next  = (POLL_WAIT == 0) ? POLL_AR : POLL_IDLE;
      end
      POLL_IDLE: begin
        if (r_cnt + 32'd1 >= LP_POLL_WAIT) begin
          w_state_next = POLL_AR;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end
      default: w_state_next = WAIT_START;
    endcase

`ifdef ACL_SEQ_TIMEOUT_EN
    // Cleared on every state change; expiry abandons the transaction and
    // restarts the init sequence without the startup delay.
    w_wdog_next = '0;
    if (w_wdog_run && (w_state_next == r_state)) begin
      if (r_wdog + 32'd1 >= LP_TIMEOUT) begin
        w_state_next     = INIT_WR;
        w_idx_next       = '0;
        w_rd_idx_next    = '0;
        w_cnt_next       = '0;
        w_aw_done_next   = 1'b0;
        w_w_done_next    = 1'b0;
        w_ar_hold_next   = 1'b0;
        w_shadow_next    = '0;
        w_init_done_next = 1'b0;
        w_resp_err_next  = 1'b1;
      end else begin
        w_wdog_next = r_wdog + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state        <= WAIT_START;
      r_cnt          <= '0;
      r_idx          <= '0;
      r_rd_idx       <= '0;
      r_aw_done      <= 1'b0;
      r_w_done       <= 1'b0;
      r_ar_hold      <= 1'b0;
      r_shadow       <= '0;
      r_sample_data  <= '0;
      r_sample_valid <= 1'b0;
      r_init_done    <= 1'b0;
      r_resp_err     <= 1'b0;
`ifdef ACL_SEQ_TIMEOUT_EN
      r_wdog         <= '0;
`endif
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_idx          <= w_idx_next;
      r_rd_idx       <= w_rd_idx_next;
      r_aw_done      <= w_aw_done_next;
      r_w_done       <= w_w_done_next;
      r_ar_hold      <= w_ar_hold_next;
      r_shadow       <= w_shadow_next;
      r_sample_data  <= w_sample_data_next;
      r_sample_valid <= w_sample_valid_next;
      r_init_done    <= w_init_done_next;
      r_resp_err     <= w_resp_err_next;
`ifdef ACL_SEQ_TIMEOUT_EN
      r_wdog         <= w_wdog_next;
`endif
    end
  end

endmodule

// File: tb/tb_acl_reg_sequencer.sv
// Testbench for acl_reg_sequencer: table-driven frame vectors plus hand-written
// sequences for startup timing, write stalls, enable gating, reset and watchdog.
module tb_acl_reg_sequencer;

  localparam int POLL_W = 5;

  logic        sys_clk, sys_rst, enable;
  logic        reg_awvalid, reg_awready, reg_wvalid, reg_wready;
  logic [5:0]  reg_awaddr, reg_araddr;
  logic [7:0]  reg_wdata, reg_rdata;
  logic        reg_bvalid, reg_bready, reg_arvalid, reg_arready, reg_rvalid, reg_rready;
  logic [1:0]  reg_bresp, reg_rresp;
  logic [23:0] sample_data;
  logic        sample_valid, init_done, resp_err;

  acl_reg_sequencer #(
    .NUM_RD(3), .START_WAIT(16), .POLL_WAIT(POLL_W), .TIMEOUT(32)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable),
    .reg_awvalid(reg_awvalid), .reg_awready(reg_awready), .reg_awaddr(reg_awaddr),
    .reg_wvalid(reg_wvalid), .reg_wready(reg_wready), .reg_wdata(reg_wdata),
    .reg_bvalid(reg_bvalid), .reg_bready(reg_bready), .reg_bresp(reg_bresp),
    .reg_arvalid(reg_arvalid), .reg_arready(reg_arready), .reg_araddr(reg_araddr),
    .reg_rvalid(reg_rvalid), .reg_rready(reg_rready), .reg_rdata(reg_rdata), .reg_rresp(reg_rresp),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .init_done(init_done), .resp_err(resp_err)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #2;
  endtask

  // ---------------- slave model ----------------
  int          aw_stall;
  bit          ar_block;
  int          aw_hi, w_hi, aw_cnt, w_cnt, b_cnt, ar_cnt, rd_cnt, ri;
  int          aw_len [8];
  int          w_len [8];
  logic [5:0]  wr_addr [8];
  logic [7:0]  wr_data [8];
  logic [5:0]  ar_log [64];
  bit          aw_got, w_got, b_pend, r_pend;
  logic [5:0]  r_addr;
  logic [7:0]  fb [3];
  logic [1:0]  resp1;

  initial begin
    reg_awready = 0; reg_wready = 0; reg_bvalid = 0; reg_bresp = 0;
    reg_arready = 0; reg_rvalid = 0; reg_rdata = 0; reg_rresp = 0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        aw_hi = 0; w_hi = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; rd_cnt = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; r_addr = 0;
        reg_awready = 0; reg_wready = 0; reg_bvalid = 0; reg_arready = 0; reg_rvalid = 0;
        reg_rdata = 0; reg_rresp = 0;
      end else begin
        reg_awready = (aw_hi >= aw_stall);
        reg_wready  = 1'b1;
        reg_bvalid  = b_pend;
        reg_bresp   = 2'b00;
        reg_arready = !ar_block;
        reg_rvalid  = r_pend;
        ri = int'(r_addr) - 8;
        reg_rdata   = (r_pend && ri >= 0 && ri < 3) ? fb[ri] : 8'h00;
        reg_rresp   = (r_pend && r_addr == 6'h09) ? resp1 : 2'b00;
        #1;
        // handshakes that will complete at the coming rising edge
        if (reg_awvalid) aw_hi++;
        if (reg_wvalid) w_hi++;
        if (reg_awvalid && reg_awready) begin
          if (aw_cnt < 8) begin aw_len[aw_cnt] = aw_hi; wr_addr[aw_cnt] = reg_awaddr; end
          aw_cnt++; aw_hi = 0; aw_got = 1;
        end
        if (reg_wvalid && reg_wready) begin
          if (w_cnt < 8) begin w_len[w_cnt] = w_hi; wr_data[w_cnt] = reg_wdata; end
          w_cnt++; w_hi = 0; w_got = 1;
        end
        if (reg_bvalid && reg_bready) begin b_cnt++; b_pend = 0; end
        if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
        if (reg_rvalid && reg_rready) begin rd_cnt++; r_pend = 0; end
        if (reg_arvalid && reg_arready) begin
          if (ar_cnt < 64) ar_log[ar_cnt] = reg_araddr;
          ar_cnt++; r_pend = 1; r_addr = reg_araddr;
        end
      end
    end
  end

  // ---------------- frame vectors ----------------
  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [1:0]  resp1;
    logic [23:0] exp_data;
    logic        exp_err;
  } frame_vec_t;

  localparam int NV = 5;
  frame_vec_t vec [NV];

  initial begin
    #500000;
    $display("FAIL tb_timeout: simulation did not reach the end");
    $fatal(1, "bench time limit");
  end

  initial begin
    int cyc, n, hi;
    bit got, leak;
    logic [23:0] prev;

    vec[0] = '{8'h11, 8'h22, 8'h33, 2'b00, 24'h332211, 1'b0};
    vec[1] = '{8'hA5, 8'h5A, 8'hFF, 2'b00, 24'hFF5AA5, 1'b0};
    vec[2] = '{8'h01, 8'h02, 8'h03, 2'b10, 24'h030201, 1'b1};
    vec[3] = '{8'hDE, 8'hAD, 8'hBE, 2'b00, 24'hBEADDE, 1'b1};
    vec[4] = '{8'h00, 8'h80, 8'h7F, 2'b00, 24'h7F8000, 1'b1};

    sys_rst = 1; enable = 1; aw_stall = 0; ar_block = 0;
    fb[0] = vec[0].b0; fb[1] = vec[0].b1; fb[2] = vec[0].b2; resp1 = vec[0].resp1;
    repeat (4) @(negedge sys_clk);
    #2;
    check("reset_valids", {26'd0, reg_awvalid, reg_wvalid, reg_bready, reg_arvalid, reg_rready, sample_valid}, 32'd0);
    check("reset_addr_data", {12'd0, reg_awaddr, reg_wdata, reg_araddr}, 32'd0);
    check("reset_sample_data", sample_data, 32'd0);
    check("reset_flags", {30'd0, init_done, resp_err}, 32'd0);

    // ---- startup delay and zero-latency init ----
    @(negedge sys_clk);
    sys_rst = 0;
    cyc = 1;
    for (int i = 0; i < 40; i++) begin
      tick(); cyc++;
      if (reg_awvalid) break;
    end
    check("first_aw_cycle", cyc, 17);
    check("first_aw_addr", reg_awaddr, 32'h27);
    check("first_w_data", reg_wdata, 32'h00);

    got = 0;
    for (int i = 0; i < 50; i++) begin
      if (b_cnt == 2) begin got = 1; break; end
      tick();
    end
    check("second_b_seen", got, 1);
    check("init_done_before_b2", init_done, 0);
    tick();
    check("init_done_after_b2", init_done, 1);
    check("write0", {wr_addr[0], wr_data[0]}, {6'h27, 8'h00});
    check("write1", {wr_addr[1], wr_data[1]}, {6'h2D, 8'h02});

    // ---- table-driven frames ----
    prev = 24'h0;
    for (int k = 0; k < NV; k++) begin
      got = 0; leak = 0;
      for (int i = 0; i < 300; i++) begin
        if (sample_valid) begin got = 1; break; end
        if (sample_data !== prev) leak = 1;
        tick();
      end
      check($sformatf("frame%0d_valid", k), got, 1);
      check($sformatf("frame%0d_data", k), sample_data, vec[k].exp_data);
      check($sformatf("frame%0d_resp_err", k), resp_err, vec[k].exp_err);
      check($sformatf("frame%0d_no_partial", k), leak, 0);
      if (k == 0) check("frame0_araddrs", {14'd0, ar_log[0], ar_log[1], ar_log[2]}, {14'd0, 6'h08, 6'h09, 6'h0A});
      prev = vec[k].exp_data;
      if (k + 1 < NV) begin
        fb[0] = vec[k+1].b0; fb[1] = vec[k+1].b1; fb[2] = vec[k+1].b2; resp1 = vec[k+1].resp1;
      end
      n = 0;
      for (int i = 0; i < 50; i++) begin
        tick(); n++;
        if (n == 1) check($sformatf("frame%0d_pulse_width", k), sample_valid, 0);
        if (reg_arvalid) break;
      end
      check($sformatf("frame%0d_next_start", k), n, POLL_W + 1);
      check($sformatf("frame%0d_next_addr", k), reg_araddr, 32'h08);
    end

    // ---- enable dropped mid-frame ----
    fb[0] = 8'h44; fb[1] = 8'h55; fb[2] = 8'h66; resp1 = 2'b00;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (reg_arvalid && reg_araddr == 6'h09) begin got = 1; break; end
      tick();
    end
    check("mid_frame_reached", got, 1);
    @(posedge sys_clk); #1 enable = 0;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (sample_valid) begin got = 1; break; end
    end
    check("disabled_frame_completes", got, 1);
    check("disabled_frame_data", sample_data, 32'h665544);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (reg_arvalid) hi++;
    end
    check("no_ar_while_disabled", hi, 0);
    @(posedge sys_clk); #1 enable = 1;
    tick();
    check("ar_after_enable", {reg_arvalid, reg_araddr}, {1'b1, 6'h08});

    // ---- reset mid-transaction, then stalled awready with enable low ----
    @(negedge sys_clk);
    sys_rst = 1; aw_stall = 3; enable = 0;
    repeat (3) @(negedge sys_clk);
    #2;
    check("reset_abandons_ar", reg_arvalid, 0);
    check("reset_clears_err", resp_err, 0);
    @(negedge sys_clk);
    sys_rst = 0;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (init_done) begin got = 1; break; end
    end
    check("stall_init_done", got, 1);
    check("stall_aw_len0", aw_len[0], 4);
    check("stall_w_len0", w_len[0], 1);
    check("stall_aw_len1", aw_len[1], 4);
    check("stall_counts", {aw_cnt[7:0], w_cnt[7:0], b_cnt[7:0]}, {8'd2, 8'd2, 8'd2});
    check("stall_write1", {wr_addr[1], wr_data[1]}, {6'h2D, 8'h02});
    check("stall_sample_data_reset", sample_data, 32'h0);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (reg_arvalid) hi++;
    end
    check("init_ignores_enable_no_poll", hi, 0);

`ifdef ACL_SEQ_TIMEOUT_EN
    // ---- watchdog: read address never accepted ----
    ar_block = 1;
    tick();
    @(posedge sys_clk); #1 enable = 1;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (reg_arvalid) hi++;
      else if (hi > 0) break;
    end
    check("wdog_ar_cycles", hi, 32);
    check("wdog_resp_err", resp_err, 1);
    check("wdog_init_done", init_done, 0);
    check("wdog_restart_aw", {reg_awvalid, reg_awaddr}, {1'b1, 6'h27});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
